// File: rtl/mdiv_ctrl_if.sv
// rtl/mdiv_ctrl_if.sv - issue/multiplier/divider/response bundle for mdiv_ctrl
//
// Ports grouped here:
//   req_*   : op offer from EX issue (valid/ready, funct3, rs1, rs2, tag)
//   mul_*   : unsigned operands out, combinational 64-bit product back
//   div_*   : start pulse and held operands out, done/quotient/remainder back
//   resp_*  : 32-bit result and tag with valid/ready
//   busy    : controller is not idle
// slave is the controller's view, master is the environment's view.
interface mdiv_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_p;

  logic             div_start;
  logic [31:0]      div_a;
  logic [31:0]      div_b;
  logic             div_done;
  logic [31:0]      div_q;
  logic [31:0]      div_r;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  logic             busy;

  modport slave (
    input  req_valid, req_funct3, req_a, req_b, req_tag,
    input  mul_p, div_done, div_q, div_r, resp_ready,
    output req_ready, mul_a, mul_b, div_start, div_a, div_b,
    output resp_valid, resp_data, resp_tag, busy
  );

  modport master (
    output req_valid, req_funct3, req_a, req_b, req_tag,
    output mul_p, div_done, div_q, div_r, resp_ready,
    input  req_ready, mul_a, mul_b, div_start, div_a, div_b,
    input  resp_valid, resp_data, resp_tag, busy
  );
endinterface

// File: rtl/mdiv_ctrl.sv
// rtl/mdiv_ctrl.sv - RV32M multiply/divide sequencing controller
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   flush  : kill in-flight op and pending response
//   bus    : mdiv_ctrl_if.slave (request, multiplier, divider, response, busy)
module mdiv_ctrl #(
  parameter int TAG_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  mdiv_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_SPECIAL,
    S_DIV_START,
    S_DIV_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             div_start_q, div_start_d;
  logic [31:0]      div_a_q, div_a_d;
  logic [31:0]      div_b_q, div_b_d;

  // rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic a_is_signed(input logic [2:0] f);
    case (f)
      3'd0, 3'd1, 3'd2, 3'd4, 3'd6: a_is_signed = 1'b1;
      default:                      a_is_signed = 1'b0;
    endcase
  endfunction

  // rs2 is signed for MUL, MULH, DIV, REM.
  function automatic logic b_is_signed(input logic [2:0] f);
    case (f)
      3'd0, 3'd1, 3'd4, 3'd6: b_is_signed = 1'b1;
      default:                b_is_signed = 1'b0;
    endcase
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic neg);
    mag = neg ? (~x + 32'd1) : x;
  endfunction

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s;
  logic [31:0] special_res;
  logic        req_a_neg, req_b_neg;
  logic        req_special;
  logic        accept;
  logic        req_ready;

  // Sign handling on the registered op.
  always_comb begin
    a_neg  = a_q[31] & a_is_signed(funct3_q);
    b_neg  = b_q[31] & b_is_signed(funct3_q);
    mag_a  = mag(a_q, a_neg);
    mag_b  = mag(b_q, b_neg);
    prod_s = (a_neg ^ b_neg) ? (~bus.mul_p + 64'd1) : bus.mul_p;
    quot_s = (a_neg ^ b_neg) ? (~bus.div_q + 32'd1) : bus.div_q;
    rem_s  = a_neg ? (~bus.div_r + 32'd1) : bus.div_r;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    if (b_q == 32'd0) begin
      special_res = funct3_q[1] ? a_q : 32'hFFFF_FFFF;
    end else begin
      special_res = funct3_q[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Classification of the op being offered.
  always_comb begin
    req_a_neg   = bus.req_a[31] & a_is_signed(bus.req_funct3);
    req_b_neg   = bus.req_b[31] & b_is_signed(bus.req_funct3);
    req_special = (bus.req_b == 32'd0) ||
                  (((bus.req_funct3 == 3'd4) || (bus.req_funct3 == 3'd6)) &&
                   (bus.req_a == 32'h8000_0000) && (bus.req_b == 32'hFFFF_FFFF));
    req_ready   = (state_q == S_IDLE) && !flush && !rst;
    accept      = bus.req_valid && req_ready;
  end

  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    a_d          = a_q;
    b_d          = b_q;
    tag_d        = tag_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    div_start_d  = 1'b0;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          funct3_d = bus.req_funct3;
          a_d      = bus.req_a;
          b_d      = bus.req_b;
          tag_d    = bus.req_tag;
          if (!bus.req_funct3[2]) begin
            state_d = S_MUL;
          end else if (req_special) begin
            state_d = S_SPECIAL;
          end else begin
            // Divider operands are loaded with the start pulse and held
            // until the next divide is accepted.
            state_d     = S_DIV_START;
            div_start_d = 1'b1;
            div_a_d     = mag(bus.req_a, req_a_neg);
            div_b_d     = mag(bus.req_b, req_b_neg);
          end
        end
      end

      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_tag_d   = tag_q;
          resp_data_d  = (funct3_q == 3'd0) ? prod_s[31:0] : prod_s[63:32];
        end
      end

      S_SPECIAL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_tag_d   = tag_q;
          resp_data_d  = special_res;
        end
      end

      S_DIV_START: begin
        state_d = flush ? S_DRAIN : S_DIV_WAIT;
      end

      S_DIV_WAIT: begin
        if (bus.div_done) begin
          // A flush coinciding with done has nothing left to drain.
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_tag_d   = tag_q;
            resp_data_d  = funct3_q[1] ? rem_s : quot_s;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      S_RESP: begin
        if (flush || bus.resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (bus.div_done) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      funct3_q     <= 3'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      resp_tag_q   <= '0;
      div_start_q  <= 1'b0;
      div_a_q      <= 32'd0;
      div_b_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      div_start_q  <= div_start_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mul_a      = (state_q == S_MUL) ? mag_a : 32'd0;
  assign bus.mul_b      = (state_q == S_MUL) ? mag_b : 32'd0;
  assign bus.div_start  = div_start_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_mdiv_ctrl.sv
// tb/tb_mdiv_ctrl.sv - directed table-driven bench for mdiv_ctrl
module tb_mdiv_ctrl;

  localparam int K_MUL = 0;
  localparam int K_SPC = 1;
  localparam int K_DIV = 2;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          kind;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  mdiv_ctrl_if #(.TAG_W(5)) bus ();

  mdiv_ctrl #(.TAG_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mul_p = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Divider stub: done fires stub_lat cycles after the start cycle.
  int          stub_lat = 1;
  int          stub_cnt;
  logic        stub_busy;
  logic [31:0] stub_a, stub_b;
  int          start_count = 0;
  int          done_cyc = -1;

  initial begin
    bus.div_done = 1'b0;
    bus.div_q    = 32'd0;
    bus.div_r    = 32'd0;
    stub_busy    = 1'b0;
    stub_cnt     = 0;
    forever begin
      @(negedge clk);
      if (bus.div_done) bus.div_done = 1'b0;
      if (stub_busy) begin
        stub_cnt = stub_cnt - 1;
        if (stub_cnt == 0) begin
          bus.div_done = 1'b1;
          bus.div_q    = stub_a / stub_b;
          bus.div_r    = stub_a % stub_b;
          stub_busy    = 1'b0;
          done_cyc     = cyc;
        end
      end else if (bus.div_start) begin
        start_count = start_count + 1;
        stub_cnt    = stub_lat;
        stub_busy   = 1'b1;
        stub_a      = bus.div_a;
        stub_b      = bus.div_b;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer at the current negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_tag    = tag;
    #1;
    chk("req_ready_idle", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_valid_after_hs", bus.resp_valid, 0);
    chk("busy_after_hs", bus.busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  s0;
    bit  got;
    s0       = start_count;
    stub_lat = v.lat;
    send(v.f, v.a, v.b, v.tag);
    if (v.kind == K_DIV) begin
      chk($sformatf("v%0d_div_start", idx), bus.div_start, 1);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.resp_valid) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("v%0d_resp_seen", idx), got, 1);
      if (got) chk($sformatf("v%0d_resp_lat", idx), cyc, done_cyc + 1);
    end else begin
      chk($sformatf("v%0d_valid_t1", idx), bus.resp_valid, 0);
      chk($sformatf("v%0d_busy_t1", idx), bus.busy, 1);
      @(negedge clk);
      chk($sformatf("v%0d_valid_t2", idx), bus.resp_valid, 1);
    end
    chk($sformatf("v%0d_data", idx), bus.resp_data, v.exp);
    chk($sformatf("v%0d_tag", idx), bus.resp_tag, v.tag);
    chk($sformatf("v%0d_starts", idx), start_count - s0, (v.kind == K_DIV) ? 1 : 0);
    handshake();
  endtask

  task automatic wait_done(input string name, input int prev);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (done_cyc != prev) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1);
  endtask

  vec_t vecs [20];

  initial begin
    int  prev;
    bit  bad;
    vec_t extra;

    rst            = 1'b1;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.req_tag    = 5'd0;
    bus.resp_ready = 1'b0;

    vecs[0]  = '{f:3'd1, a:32'hFFFF_FFFF, b:32'd2,        tag:5'd1,  kind:K_MUL, lat:1,  exp:32'hFFFF_FFFF};
    vecs[1]  = '{f:3'd0, a:32'hFFFF_FFFF, b:32'd2,        tag:5'd2,  kind:K_MUL, lat:1,  exp:32'hFFFF_FFFE};
    vecs[2]  = '{f:3'd3, a:32'hFFFF_FFFF, b:32'd2,        tag:5'd3,  kind:K_MUL, lat:1,  exp:32'h0000_0001};
    vecs[3]  = '{f:3'd2, a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, tag:5'd4, kind:K_MUL, lat:1,  exp:32'hFFFF_FFFF};
    vecs[4]  = '{f:3'd0, a:32'h1234_5678, b:32'h10,       tag:5'd5,  kind:K_MUL, lat:1,  exp:32'h2345_6780};
    vecs[5]  = '{f:3'd1, a:32'h8000_0000, b:32'h8000_0000, tag:5'd6, kind:K_MUL, lat:1,  exp:32'h4000_0000};
    vecs[6]  = '{f:3'd4, a:32'hFFFF_FFF9, b:32'd2,        tag:5'd7,  kind:K_DIV, lat:33, exp:32'hFFFF_FFFD};
    vecs[7]  = '{f:3'd6, a:32'hFFFF_FFF9, b:32'd2,        tag:5'd8,  kind:K_DIV, lat:33, exp:32'hFFFF_FFFF};
    vecs[8]  = '{f:3'd5, a:32'd100,       b:32'd7,        tag:5'd9,  kind:K_DIV, lat:3,  exp:32'd14};
    vecs[9]  = '{f:3'd7, a:32'd100,       b:32'd7,        tag:5'd10, kind:K_DIV, lat:3,  exp:32'd2};
    vecs[10] = '{f:3'd4, a:32'd7,         b:32'hFFFF_FFFE, tag:5'd11, kind:K_DIV, lat:1, exp:32'hFFFF_FFFD};
    vecs[11] = '{f:3'd6, a:32'd7,         b:32'hFFFF_FFFE, tag:5'd12, kind:K_DIV, lat:1, exp:32'd1};
    vecs[12] = '{f:3'd5, a:32'd5,         b:32'd0,        tag:5'd13, kind:K_SPC, lat:1,  exp:32'hFFFF_FFFF};
    vecs[13] = '{f:3'd6, a:32'd5,         b:32'd0,        tag:5'd14, kind:K_SPC, lat:1,  exp:32'd5};
    vecs[14] = '{f:3'd4, a:32'h8000_0000, b:32'hFFFF_FFFF, tag:5'd15, kind:K_SPC, lat:1, exp:32'h8000_0000};
    vecs[15] = '{f:3'd6, a:32'h8000_0000, b:32'hFFFF_FFFF, tag:5'd16, kind:K_SPC, lat:1, exp:32'd0};
    vecs[16] = '{f:3'd5, a:32'h8000_0000, b:32'hFFFF_FFFF, tag:5'd17, kind:K_DIV, lat:2, exp:32'd0};
    vecs[17] = '{f:3'd7, a:32'h8000_0000, b:32'hFFFF_FFFF, tag:5'd18, kind:K_DIV, lat:2, exp:32'h8000_0000};
    vecs[18] = '{f:3'd4, a:32'hFFFF_FFFF, b:32'd0,        tag:5'd19, kind:K_SPC, lat:1,  exp:32'hFFFF_FFFF};
    vecs[19] = '{f:3'd7, a:32'hFFFF_FFF9, b:32'd0,        tag:5'd20, kind:K_SPC, lat:1,  exp:32'hFFFF_FFF9};

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_tag", bus.resp_tag, 0);
    chk("rst_div_start", bus.div_start, 0);
    chk("rst_mul_ab", {bus.mul_a, bus.mul_b}, 0);
    chk("rst_div_ab", {bus.div_a, bus.div_b}, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Backpressure: response held ten cycles while a second op waits.
    send(3'd0, 32'd3, 32'd5, 5'h1A);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'd3;
    bus.req_a      = 32'hFFFF_FFFF;
    bus.req_b      = 32'hFFFF_FFFF;
    bus.req_tag    = 5'h05;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_valid_%0d", i), bus.resp_valid, 1);
      chk($sformatf("bp_data_%0d", i), bus.resp_data, 32'd15);
      chk($sformatf("bp_tag_%0d", i), bus.resp_tag, 5'h1A);
      chk($sformatf("bp_req_ready_%0d", i), bus.req_ready, 0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("bp_hs_valid", bus.resp_valid, 0);
    chk("bp_next_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_next_busy", bus.busy, 1);
    @(negedge clk);
    chk("bp_next_valid", bus.resp_valid, 1);
    chk("bp_next_data", bus.resp_data, 32'hFFFF_FFFE);
    chk("bp_next_tag", bus.resp_tag, 5'h05);
    handshake();

    // Flush in IDLE alongside a request: not accepted.
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_a      = 32'd1;
    bus.req_b      = 32'd1;
    flush          = 1'b1;
    #1;
    chk("idle_flush_ready", bus.req_ready, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    chk("idle_flush_busy", bus.busy, 0);

    // Flush one cycle after div_start: drain, no response.
    stub_lat = 8;
    prev     = done_cyc;
    bus.resp_ready = 1'b1;
    send(3'd4, 32'd20, 32'd3, 5'd3);
    chk("fl_div_start", bus.div_start, 1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bad   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (done_cyc != prev) break;
      if (bus.resp_valid || !bus.busy || bus.req_ready) bad = 1'b1;
      @(negedge clk);
    end
    chk("fl_drain_seen_done", (done_cyc != prev), 1);
    chk("fl_drain_quiet", bad, 0);
    chk("fl_busy_at_done", bus.busy, 1);
    @(negedge clk);
    chk("fl_busy_after", bus.busy, 0);
    chk("fl_ready_after", bus.req_ready, 1);
    chk("fl_no_resp", bus.resp_valid, 0);
    bus.resp_ready = 1'b0;

    // Flush during DIV_START: start still issued, then drain.
    stub_lat = 4;
    prev     = done_cyc;
    send(3'd5, 32'd50, 32'd5, 5'd6);
    flush = 1'b1;
    chk("fs_div_start", bus.div_start, 1);
    @(negedge clk);
    flush = 1'b0;
    chk("fs_busy", bus.busy, 1);
    wait_done("fs_done_seen", prev);
    @(negedge clk);
    chk("fs_busy_after", bus.busy, 0);
    chk("fs_no_resp", bus.resp_valid, 0);

    // Reset in DIV_WAIT; the divider's later done pulse is ignored.
    stub_lat = 20;
    prev     = done_cyc;
    send(3'd4, 32'd9, 32'd2, 5'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rw_busy", bus.busy, 0);
    chk("rw_resp_valid", bus.resp_valid, 0);
    #1;
    chk("rw_req_ready", bus.req_ready, 1);
    wait_done("rw_late_done", prev);
    @(negedge clk);
    chk("rw_busy_after_done", bus.busy, 0);
    chk("rw_valid_after_done", bus.resp_valid, 0);

    extra = '{f:3'd0, a:32'hFFFF_FFFD, b:32'hFFFF_FFFD, tag:5'd31, kind:K_MUL, lat:1, exp:32'd9};
    run_vec(extra, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdiv_ctrl.md
# mdiv_ctrl

Sequencing controller for the RV32M multiply/divide unit. Sits between the EX-stage issue logic and the shared unsigned multiplier (combinational, 64-bit product) and unsigned multi-cycle divider (start/done). It accepts one M-extension op at a time, converts operands to magnitudes, and starts the divider or captures the product. It resolves divide-by-zero and signed overflow without using the divider, applies sign correction, and returns a 32-bit result through a valid/ready handshake. It also supports pipeline flush while the divider is busy.

## Interface
- TAG_W, 5: width of destination tag carried with each op
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- flush  in  1  kill in-flight op and pending response
- req_valid  in  1  op offered
- req_ready  out  1  controller accepts op this cycle
- req_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- req_a, req_b  in  32  rs1, rs2 values
- req_tag  in  TAG_W  destination tag
- mul_a, mul_b  out  32  unsigned operands to multiplier
- mul_p  in  64  unsigned product, combinational from mul_a/mul_b
- div_start  out  1  one-cycle start pulse to divider
- div_a, div_b  out  32  unsigned dividend/divisor, held stable from div_start until div_done
- div_done  in  1  one-cycle pulse; div_q/div_r valid in that cycle
- div_q, div_r  in  32  unsigned quotient, remainder
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result
- resp_tag  out  TAG_W  tag of result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, MUL, SPECIAL, DIV_START, DIV_WAIT, RESP, DRAIN.
- IDLE: req_ready = 1 unless flush or rst. On req_valid&req_ready, register funct3, a, b, tag.
  - funct3<4: next state MUL.
  - funct3>=4 with b==0, or signed op (4, 6) with a==0x80000000 and b==0xFFFFFFFF: next state SPECIAL.
  - All other funct3>=4: next state DIV_START.
- Signedness:
  - a_neg = a[31] for funct3 in {0,1,2,4,6}.
  - b_neg = b[31] for funct3 in {0,1,4,6}.
  - Magnitudes: |x| = x_neg ? (~x+1) : x, 32-bit. |0x80000000| = 0x80000000 unsigned.
- MUL: mul_a/mul_b = magnitudes. p = (a_neg^b_neg) ? (~mul_p+1) : mul_p, 64-bit. Result is p[31:0] for MUL and p[63:32] for funct3 1..3. Capture, go to RESP.
- DIV_START: div_start = 1 for exactly this cycle, div_a/div_b = magnitudes, go to DIV_WAIT.
- DIV_WAIT: on div_done, capture the result and go to RESP.
  - DIV/DIVU result: (a_neg^b_neg) ? -q : q.
  - REM/REMU result: a_neg ? -r : r.
- SPECIAL:
  - b==0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> a (unmodified).
  - Overflow: DIV -> 0x80000000; REM -> 0.
  - Go to RESP.
- RESP: resp_valid = 1; resp_data/resp_tag stable until resp_valid&resp_ready, then go to IDLE. No new op is accepted in the handshake cycle.
- Flush:
  - In IDLE: no effect; a simultaneous req_valid is not accepted.
  - In MUL, SPECIAL or RESP: go to IDLE next cycle; resp_valid drops, result discarded.
  - In DIV_START: div_start is still issued; go to DRAIN.
  - In DIV_WAIT: go to DRAIN.
  - DRAIN: wait for div_done, discard the result, then go to IDLE. Flush in DRAIN has no further effect.
- Reset mid-operation: state forced to IDLE even while the divider is busy. The divider shares rst and is reset with the controller, so no DRAIN is needed.

## Timing
- Reset values:
  - state IDLE, resp_valid 0, resp_data 0, resp_tag 0, div_start 0, busy 0.
  - req_ready 0 while rst is high.
  - mul_a, mul_b, div_a, div_b 0.
- Accept at edge t:
  - MUL ops: resp_valid first high in cycle t+2.
  - SPECIAL ops: resp_valid first high in cycle t+2.
  - DIV ops: div_start high in cycle t+1. If div_done arrives in cycle d (d>=t+2), resp_valid is high in cycle d+1.
- Back-to-back: the next op is accepted no earlier than the cycle after the response handshake. Peak throughput is one MUL per 3 cycles.
- All outputs are registered except req_ready, busy and the mul_a/mul_b drive, which are decoded from state and registered operands.
- div_done while not in DIV_WAIT or DRAIN is ignored.

## Test plan
- MULH a=0xFFFFFFFF (-1), b=0x00000002 -> resp_data 0xFFFFFFFF; MUL on the same operands -> 0xFFFFFFFE; MULHU on the same operands -> 0x00000001; each resp_valid at t+2.
- DIV a=0xFFFFFFF9 (-7), b=2 with stub divider done 33 cycles after start -> resp_data 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. resp_valid one cycle after div_done.
- DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, REM -> 0. div_start never asserted.
- Backpressure: hold resp_ready=0 for 10 cycles after resp_valid. resp_data/resp_tag stay stable and req_ready stays 0. Accept on release; the next req is accepted in the following cycle.
- Flush one cycle after a DIV starts: no response is emitted, busy stays high until div_done, and req_ready returns the cycle after div_done. Flush in the same cycle as req_valid: op not accepted.
- Assert rst during DIV_WAIT: the next cycle has busy=0, resp_valid=0 and req_ready=1 after rst deasserts. A later div_done pulse is ignored.
